leds_sequencer: RTL
===================

// Module: leds_sequencer
// PURPOSE
//   Command-driven pattern controller for the 8-LED bank. Accepts {mode, repeat}
//   commands over a valid/ready handshake. Steps the LEDs once every DELAY_TICKS
//   clocks, runs the requested number of passes, then reports completion.
//   Sits between the board control logic (or a CPU register) and the LED pins.
// PARAMETERS
//   DELAY_TICKS  32'd50  clocks per LED step; a value of 0 is treated as 1
// PORTS
//   clock       in   1  system clock; all logic on its rising edge
//   reset_n     in   1  synchronous, active-low reset
//   cmd_valid   in   1  command present
//   cmd_ready   out  1  controller can accept a command (high only in IDLE)
//   cmd_mode    in   2  0=OFF, 1=SCAN_LEFT, 2=BOUNCE, 3=BLINK
//   cmd_repeat  in   8  passes to run; 0 = run until stop
//   stop        in   1  abort the running pattern
//   leds        out  8  LED drive, registered
//   busy        out  1  high while in RUN
//   done        out  1  one-cycle pulse when the final pass completes
// BEHAVIOUR
// - Reset (reset_n=0 at a clock edge): state=IDLE, leds=8'h00, busy=0, done=0,
//   tick counter=0, pass counter=0, bounce direction=left. cmd_ready=1.
//   A reset during RUN aborts the pattern the same way. No done pulse is issued.
// - cmd_ready is combinational and equals (state==IDLE). The command is accepted
//   on an edge where cmd_valid && cmd_ready; cmd_mode and cmd_repeat are latched there.
// - A command with mode OFF: stay IDLE, leds=00, done=1 for the next cycle only.
//   busy is never asserted.
// - Any other mode: at the accept edge, state=RUN, busy=1, tick=0, passes=0, dir=left.
//   leds=8'h01 for SCAN_LEFT/BOUNCE and 8'hFF for BLINK.
// - Tick: in RUN, tick increments each cycle. At tick==DELAY_TICKS-1, a step occurs
//   and tick returns to 0. Each pattern value therefore holds exactly DELAY_TICKS cycles.
// - Step rules:
//   SCAN_LEFT: rotate left, 80->01 wraps. One pass = 8 steps.
//   BOUNCE: shift in dir. Reverse at 80 (going left) and at 01 (going right).
//     One pass = 14 steps, 01->80->01; no endpoint is shown twice in a row.
//   BLINK: toggle FF<->00. One pass = 2 steps.
// - Pass end: on the step that completes a pass, passes increments (8-bit).
//   If cmd_repeat!=0 and passes+1==cmd_repeat, that step does not advance the pattern.
//   Instead: state=IDLE, leds=00, busy=0, done=1 for one cycle.
//   If cmd_repeat==0, passes wraps 255->0 silently and the pattern continues.
// - stop: in RUN, at the next edge state=IDLE, leds=00, busy=0, done stays 0.
//   If stop coincides with the final step, stop wins and there is no done.
//   stop is ignored in IDLE.
// - cmd_valid during RUN is not accepted. The command is accepted on the first IDLE
//   cycle, which can be the cycle right after done.
// - Latency: accept edge to first LED change = DELAY_TICKS clocks.
//   Accept edge to done = DELAY_TICKS*steps_per_pass*cmd_repeat clocks.
// TESTING
// 1. Hold reset_n=0 for 2 cycles with cmd_valid=1 -> leds=00, busy=0, done=0,
//    cmd_ready=1, no accept.
// 2. DELAY_TICKS=4, SCAN_LEFT, repeat=1 -> leds 01,02,04..80, each for 4 cycles.
//    At cycle 32 after accept: leds=00, done=1 for 1 cycle, busy=0.
// 3. DELAY_TICKS=4, BOUNCE, repeat=2 -> leds 01..80..01 twice (28 steps, 112 cycles).
//    80 is shown exactly once per pass. One done pulse.
// 4. BLINK, repeat=0, stop asserted after 10 steps -> leds alternate FF/00.
//    Next edge after stop: leds=00, busy=0, done never 1, cmd_ready=1.
// 5. cmd_valid held with a new command during RUN -> not accepted until done.
//    Accepted on the following IDLE cycle. An OFF command gives a done pulse
//    1 cycle later, with busy=0 throughout.
// 6. reset_n=0 for 1 cycle mid-BOUNCE -> leds=00, busy=0, no done.
//    A new SCAN_LEFT command afterwards starts from 01.

Source files
------------

// File: rtl/leds_sequencer.sv
// leds_sequencer: command-driven pattern controller for an 8-LED bank.
// Takes {mode, repeat} commands over valid/ready, steps the pattern once every
// DELAY_TICKS clocks, runs the requested number of passes, then pulses done.
module leds_sequencer #(
  parameter logic [31:0] DELAY_TICKS = 32'd50
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [7:0] cmd_repeat,
  input  logic       stop,
  output logic [7:0] leds,
  output logic       busy,
  output logic       done
);

  // A zero delay would never reach its terminal count, so clamp it to one.
  localparam logic [31:0] DelayEff  = (DELAY_TICKS == 32'd0) ? 32'd1 : DELAY_TICKS;
  localparam logic [31:0] TickLast  = DelayEff - 32'd1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef enum logic [1:0] {
    ModeOff    = 2'd0,
    ModeScan   = 2'd1,
    ModeBounce = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  // Bounce direction: left moves the lit bit towards bit 7.
  typedef enum logic [0:0] {DirLeft, DirRight} dir_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  dir_e        dir_q, dir_d;
  logic [7:0]  repeat_q, repeat_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] tick_q, tick_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  passes_q, passes_d;
  logic        done_q, done_d;

  // Index of the step that closes a pass for each mode.
  function automatic logic [3:0] last_step(input mode_e m);
    unique case (m)
      ModeScan:   last_step = 4'd7;
      ModeBounce: last_step = 4'd13;
      ModeBlink:  last_step = 4'd1;
      default:    last_step = 4'd0;
    endcase
  endfunction

  // Pattern value shown right after a command is accepted.
  function automatic logic [7:0] first_pattern(input mode_e m);
    first_pattern = (m == ModeBlink) ? 8'hFF : 8'h01;
  endfunction

  // Next pattern value for one step.
  function automatic logic [7:0] next_pattern(input mode_e m, input logic [7:0] cur,
                                              input dir_e d);
    logic [7:0] nxt;
    nxt = cur;
    unique case (m)
      ModeScan:   nxt = {cur[6:0], cur[7]};
      ModeBlink:  nxt = ~cur;
      ModeBounce: begin
        // Reverse at the endpoints so neither end is shown twice in a row.
        if (d == DirLeft) begin
          nxt = (cur == 8'h80) ? {1'b0, cur[7:1]} : {cur[6:0], 1'b0};
        end else begin
          nxt = (cur == 8'h01) ? {cur[6:0], 1'b0} : {1'b0, cur[7:1]};
        end
      end
      default:    nxt = 8'h00;
    endcase
    next_pattern = nxt;
  endfunction

  // Next bounce direction for one step.
  function automatic dir_e next_dir(input mode_e m, input logic [7:0] cur, input dir_e d);
    dir_e nd;
    nd = d;
    if (m == ModeBounce) begin
      if (d == DirLeft && cur == 8'h80) begin
        nd = DirRight;
      end else if (d == DirRight && cur == 8'h01) begin
        nd = DirLeft;
      end
    end
    next_dir = nd;
  endfunction

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      mode_q   <= ModeOff;
      dir_q    <= DirLeft;
      repeat_q <= 8'h00;
      leds_q   <= 8'h00;
      tick_q   <= 32'd0;
      step_q   <= 4'd0;
      passes_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      repeat_q <= repeat_d;
      leds_q   <= leds_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      passes_q <= passes_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: command accept, tick/step timing, pass accounting, stop.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    repeat_d = repeat_q;
    leds_d   = leds_q;
    tick_d   = tick_q;
    step_d   = step_q;
    passes_d = passes_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          mode_d   = mode_e'(cmd_mode);
          repeat_d = cmd_repeat;
          if (mode_e'(cmd_mode) == ModeOff) begin
            leds_d = 8'h00;
            done_d = 1'b1;
          end else begin
            state_d  = StRun;
            tick_d   = 32'd0;
            step_d   = 4'd0;
            passes_d = 8'h00;
            dir_d    = DirLeft;
            leds_d   = first_pattern(mode_e'(cmd_mode));
          end
        end
      end

      StRun: begin
        if (stop) begin
          // Stop beats a coinciding final step: no done pulse.
          state_d = StIdle;
          leds_d  = 8'h00;
          tick_d  = 32'd0;
        end else if (tick_q == TickLast) begin
          tick_d = 32'd0;
          if (step_q == last_step(mode_q)) begin
            if (repeat_q != 8'h00 && passes_q + 8'd1 == repeat_q) begin
              // Final pass: finish instead of advancing the pattern.
              state_d  = StIdle;
              leds_d   = 8'h00;
              done_d   = 1'b1;
              passes_d = passes_q + 8'd1;
            end else begin
              passes_d = passes_q + 8'd1;
              step_d   = 4'd0;
              leds_d   = next_pattern(mode_q, leds_q, dir_q);
              dir_d    = next_dir(mode_q, leds_q, dir_q);
            end
          end else begin
            step_d = step_q + 4'd1;
            leds_d = next_pattern(mode_q, leds_q, dir_q);
            dir_d  = next_dir(mode_q, leds_q, dir_q);
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      default: begin
        state_d = StIdle;
        leds_d  = 8'h00;
      end
    endcase
  end

  // Outputs: handshake and busy decode straight from the state register.
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q == StRun);
    leds      = leds_q;
    done      = done_q;
  end

endmodule
